// File: rtl/memory_responder.sv
// Single-port memory responder: self-initialises every word to the inverted
// address after reset, then serves one read or write request per clock.
module memory_responder #(
  parameter int unsigned N = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              read_en,
  input  logic [2*N-1:0]    address,
  input  logic [2*N-1:0]    wdata,
  output logic [2*N-1:0]    data,
  output logic              data_valid,
  output logic              wr_ack,
  output logic              ready
);

  localparam int unsigned AW    = 2 * N;
  localparam int unsigned DW    = 2 * N;
  localparam int unsigned DEPTH = 2 ** AW;

  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

  typedef enum logic [0:0] {
    StInit,
    StIdle
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   init_addr_q, init_addr_d;

  logic [DW-1:0]   mem [DEPTH];

  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [DW-1:0]   mem_wdata;

  logic            rd_accept;
  logic            wr_accept;

  // Requests are only honoured once initialisation has finished; anything
  // presented earlier is dropped rather than queued.
  assign ready     = (state_q == StIdle);
  assign rd_accept = ready & en & read_en;
  assign wr_accept = ready & en & ~read_en;

  // State and init-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StInit;
      init_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
    end
  end

  // Next-state logic and the single memory write port mux (init vs. request).
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    mem_we      = 1'b0;
    mem_waddr   = address;
    mem_wdata   = wdata;
    unique case (state_q)
      StInit: begin
        mem_we    = 1'b1;
        mem_waddr = init_addr_q;
        mem_wdata = DW'(~init_addr_q);
        if (init_addr_q == LastAddr) begin
          state_d = StIdle;
        end else begin
          init_addr_d = init_addr_q + 1'b1;
        end
      end
      StIdle: begin
        mem_we    = wr_accept;
        mem_waddr = address;
        mem_wdata = wdata;
      end
      default: begin
        state_d     = StInit;
        init_addr_d = '0;
      end
    endcase
  end

  // Storage array; contents are deliberately not reset, the init sweep
  // rewrites every word after each reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Registered read data and one-cycle response pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data       <= '0;
      data_valid <= 1'b0;
      wr_ack     <= 1'b0;
    end else begin
      data_valid <= rd_accept;
      wr_ack     <= wr_accept;
      if (rd_accept) begin
        data <= mem[address];
      end
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// Directed, table-driven bench for memory_responder with N=2 (16 x 4-bit).
module tb_memory_responder;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       read_en;
  logic [3:0] address;
  logic [3:0] wdata;
  logic [3:0] data;
  logic       data_valid;
  logic       wr_ack;
  logic       ready;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string      name;
    logic       en;
    logic       rd;
    logic [3:0] addr;
    logic [3:0] wd;
    logic [3:0] xdata;
    logic       xdv;
    logic       xack;
  } vec_t;

  vec_t tbl_a[$];
  vec_t tbl_b[$];

  memory_responder #(
    .N(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .read_en    (read_en),
    .address    (address),
    .wdata      (wdata),
    .data       (data),
    .data_valid (data_valid),
    .wr_ack     (wr_ack),
    .ready      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [3:0] xd, input logic xdv,
                       input logic xack, input logic xrdy);
    n_cmp++;
    if (data !== xd || data_valid !== xdv || wr_ack !== xack || ready !== xrdy) begin
      n_err++;
      $display("FAIL %s: got data=%h dv=%b ack=%b rdy=%b, want data=%h dv=%b ack=%b rdy=%b",
               name, data, data_valid, wr_ack, ready, xd, xdv, xack, xrdy);
    end
  endtask

  // Drive one request, then sample 1 time unit after the active edge.
  task automatic step(input logic e, input logic r, input logic [3:0] a, input logic [3:0] w);
    en      = e;
    read_en = r;
    address = a;
    wdata   = w;
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(input vec_t v);
    step(v.en, v.rd, v.addr, v.wd);
    check(v.name, v.xdata, v.xdv, v.xack, 1'b1);
  endtask

  initial begin
    // Post-init expectations: mem[a] = ~a.
    for (int a = 0; a < 16; a++) begin
      tbl_a.push_back('{"sweep_rd", 1'b1, 1'b1, 4'(a), 4'h0, 4'(15 - a), 1'b1, 1'b0});
    end
    tbl_a.push_back('{"idle_hold",   1'b0, 1'b0, 4'h3, 4'h9, 4'h0, 1'b0, 1'b0});
    tbl_a.push_back('{"wr_5_to_A",   1'b1, 1'b0, 4'hA, 4'h5, 4'h0, 1'b0, 1'b1});
    tbl_a.push_back('{"raw_rd_A",    1'b1, 1'b1, 4'hA, 4'h0, 4'h5, 1'b1, 1'b0});
    tbl_a.push_back('{"rd_B_untouch",1'b1, 1'b1, 4'hB, 4'h0, 4'h4, 1'b1, 1'b0});
    tbl_a.push_back('{"idle_after",  1'b0, 1'b1, 4'hA, 4'h0, 4'h4, 1'b0, 1'b0});

    // After the mid-stream reset and re-init.
    tbl_b.push_back('{"rd_7_reinit", 1'b1, 1'b1, 4'h7, 4'h0, 4'h8, 1'b1, 1'b0});
    tbl_b.push_back('{"rd_3_nodrop", 1'b1, 1'b1, 4'h3, 4'h0, 4'hC, 1'b1, 1'b0});
    tbl_b.push_back('{"alt_wr_1_0",  1'b1, 1'b0, 4'h0, 4'h1, 4'hC, 1'b0, 1'b1});
    tbl_b.push_back('{"alt_rd_0",    1'b1, 1'b1, 4'h0, 4'h0, 4'h1, 1'b1, 1'b0});
    tbl_b.push_back('{"alt_wr_2_F",  1'b1, 1'b0, 4'hF, 4'h2, 4'h1, 1'b0, 1'b1});
    tbl_b.push_back('{"alt_rd_F",    1'b1, 1'b1, 4'hF, 4'h0, 4'h2, 1'b1, 1'b0});
    tbl_b.push_back('{"alt_idle",    1'b0, 1'b0, 4'h0, 4'h0, 4'h2, 1'b0, 1'b0});
    tbl_b.push_back('{"rd_E_pattern",1'b1, 1'b1, 4'hE, 4'h0, 4'h1, 1'b1, 1'b0});

    rst_n   = 1'b0;
    en      = 1'b0;
    read_en = 1'b0;
    address = '0;
    wdata   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_vals", 4'h0, 1'b0, 1'b0, 1'b0);

    // Release mid-cycle; ready must rise exactly on the 16th edge.
    #4 rst_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 1'b0, 4'h0, 4'h0);
      check($sformatf("init1_cyc%0d", i), 4'h0, 1'b0, 1'b0, (i == 16));
    end

    foreach (tbl_a[i]) run_table(tbl_a[i]);

    // Write 0 to 7, then reset asynchronously while wr_ack is high.
    step(1'b1, 1'b0, 4'h7, 4'h0);
    check("wr_0_to_7", 4'h4, 1'b0, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_now", 4'h0, 1'b0, 1'b0, 1'b0);
    en = 1'b0;
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;

    // Re-init with requests that must be dropped (read 3, write F to 3, read at edge 16).
    for (int i = 1; i <= 16; i++) begin
      if (i == 5)       step(1'b1, 1'b1, 4'h3, 4'h0);
      else if (i == 6)  step(1'b1, 1'b0, 4'h3, 4'hF);
      else if (i == 16) step(1'b1, 1'b1, 4'h2, 4'h0);
      else              step(1'b0, 1'b0, 4'h0, 4'h0);
      check($sformatf("init2_cyc%0d", i), 4'h0, 1'b0, 1'b0, (i == 16));
    end

    foreach (tbl_b[i]) run_table(tbl_b[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
